uart_pixel_loader: RTL and testbench

UART_PIXEL_LOADER -- requirements
Module: uart_pixel_loader

---
 rtl/uart_pixel_loader.sv | 124 ++++++++++++
 tb/tb_uart_pixel_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: clears SDRAM pages at power-up, then loads frames of UART byte pairs through a pixel FIFO
//   clk, rst                 : clock, synchronous active-high reset
//   rx_data, rx_valid        : received UART byte and its one-cycle strobe
//   load_start, page_sel     : request one frame load into page page_sel
//   FIFO_RD_req, FIFO_out    : consumer pop and first-word-fall-through head (CLEAR_COLOR while clearing)
//   FIFO_full                : FIFO level >= FILL_TH
//   startup_inc              : SDRAM accepted the current write address
//   page_set, row_add_user,
//   col_add_user             : current SDRAM write address
//   startup, load_done       : clear finished flag, frame load completion pulse
//   overflow                 : sticky, a pixel was dropped on a full FIFO
module uart_pixel_loader #(
    parameter int          H_PIX       = 800,
    parameter int          V_PIX       = 480,
    parameter int          CLEAR_PAGES = 8,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          FILL_TH     = 4,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        load_start,
    input  logic [2:0]  page_sel,
    input  logic        FIFO_RD_req,
    input  logic        startup_inc,
    output logic [15:0] FIFO_out,
    output logic        FIFO_full,
    output logic [2:0]  page_set,
    output logic [8:0]  row_add_user,
    output logic [9:0]  col_add_user,
    output logic        startup,
    output logic        load_done,
    output logic        overflow
);
    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [9:0] COL_MAX  = 10'(H_PIX - 1);
    localparam logic [8:0] ROW_MAX  = 9'(V_PIX - 1);
    localparam logic [2:0] PAGE_MAX = 3'(CLEAR_PAGES - 1);

    logic [1:0]    state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level;
    logic          phase;
    logic [7:0]    hi;
    logic          adv, col_end, row_end, page_end, push, pop, accept, start;

    assign adv      = startup_inc && state != IDLE;
    assign col_end  = col_add_user == COL_MAX;
    assign row_end  = row_add_user == ROW_MAX;
    assign page_end = page_set == PAGE_MAX;
    assign start    = state == IDLE && load_start;
    // Pairing is high byte first, so the second byte of a pair completes the pixel.
    assign push     = state == LOAD && rx_valid && phase;
    assign pop      = state != CLEAR && FIFO_RD_req && level != '0;
    // A same-cycle pop frees a slot, so a full FIFO can still take the word.
    assign accept   = push && (level < LW'(FIFO_DEPTH) || pop);

    assign FIFO_out  = state == CLEAR ? CLEAR_COLOR : mem[rd_ptr];
    assign FIFO_full = state != CLEAR && level >= LW'(FILL_TH);

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {hi, rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            startup      <= 1'b0;
            page_set     <= '0;
            row_add_user <= '0;
            col_add_user <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            phase        <= 1'b0;
            hi           <= '0;
            load_done    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (adv) begin
                col_add_user <= col_end ? '0 : col_add_user + 10'd1;
                if (col_end) begin
                    row_add_user <= row_end ? '0 : row_add_user + 9'd1;
                    if (row_end && state == LOAD) begin
                        state     <= IDLE;
                        load_done <= 1'b1;
                    end else if (row_end) begin
                        page_set <= page_end ? '0 : page_set + 3'd1;
                        if (page_end) begin
                            state   <= IDLE;
                            startup <= 1'b1;
                        end
                    end
                end
            end
            if (start) begin
                state        <= LOAD;
                page_set     <= page_sel;
                row_add_user <= '0;
                col_add_user <= '0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                level        <= '0;
                phase        <= 1'b0;
            end else begin
                if (state == LOAD && rx_valid) begin
                    phase <= ~phase;
                    if (!phase) hi <= rx_data;
                end
                if (accept) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !accept) overflow <= 1'b1;
                level <= level + LW'(accept) - LW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb_uart_pixel_loader: directed self-checking bench for uart_pixel_loader with a 4x2 page, 2 clear pages, 8-word FIFO
module tb_uart_pixel_loader;
    logic        clk = 0, rst = 0, rx_valid = 0, load_start = 0, FIFO_RD_req = 0, startup_inc = 0;
    logic [7:0]  rx_data = 0;
    logic [2:0]  page_sel = 0;
    logic [15:0] FIFO_out;
    logic        FIFO_full, startup, load_done, overflow;
    logic [2:0]  page_set;
    logic [8:0]  row_add_user;
    logic [9:0]  col_add_user;
    int tests = 0, fails = 0;

    uart_pixel_loader #(.H_PIX(4), .V_PIX(2), .CLEAR_PAGES(2), .FIFO_DEPTH(8), .FILL_TH(4), .CLEAR_COLOR(16'h0000)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .load_start(load_start),
        .page_sel(page_sel), .FIFO_RD_req(FIFO_RD_req), .startup_inc(startup_inc), .FIFO_out(FIFO_out),
        .FIFO_full(FIFO_full), .page_set(page_set), .row_add_user(row_add_user), .col_add_user(col_add_user),
        .startup(startup), .load_done(load_done), .overflow(overflow));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rd);
        rx_data = b; rx_valid = 1; FIFO_RD_req = rd;
        tick;
        rx_valid = 0; FIFO_RD_req = 0;
    endtask

    task automatic pop_one;
        FIFO_RD_req = 1;
        tick;
        FIFO_RD_req = 0;
    endtask

    task automatic run_clear;
        for (int i = 0; i < 16; i++) begin
            startup_inc = 1;
            tick;
            startup_inc = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1;
        tick; tick;
        rst = 0;
        tests++; if (startup !== 1'b0) begin fails++; $display("FAIL reset_startup got %b exp 0", startup); end
        tests++; if ({page_set, row_add_user, col_add_user} !== 22'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", {page_set, row_add_user, col_add_user}); end
        tests++; if ({FIFO_full, load_done, overflow} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {FIFO_full, load_done, overflow}); end
        tests++; if (FIFO_out !== 16'h0000) begin fails++; $display("FAIL reset_fifo_out got %h exp 0000", FIFO_out); end
    endtask

    task automatic test_clear;
        logic [37:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = {3'(i / 8), 9'((i / 4) % 2), 10'(i % 4), 16'h0000};
            tests++; if ({page_set, row_add_user, col_add_user, FIFO_out} !== exp || startup !== 1'b0 || FIFO_full !== 1'b0) begin
                fails++; $display("FAIL clear_step%0d got %h st %b full %b exp %h st 0 full 0", i, {page_set, row_add_user, col_add_user, FIFO_out}, startup, FIFO_full, exp);
            end
            startup_inc = 1; load_start = (i == 5); page_sel = 3'd7; rx_valid = i[0]; rx_data = 8'hEE; FIFO_RD_req = 1;
            tick;
            startup_inc = 0; load_start = 0; rx_valid = 0; FIFO_RD_req = 0;
            if (i < 15) tick;
        end
        tests++; if (startup !== 1'b1) begin fails++; $display("FAIL clear_startup got %b exp 1", startup); end
        tests++; if ({page_set, row_add_user, col_add_user} !== 22'h0) begin fails++; $display("FAIL clear_wrap got %h exp 0", {page_set, row_add_user, col_add_user}); end
    endtask

    task automatic test_load;
        logic [7:0]  bytes [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                                    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic [15:0] heads [7] = '{16'h9ABC, 16'hDEF0, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h0708};
        startup_inc = 1;
        tick;
        startup_inc = 0;
        tests++; if (col_add_user !== 10'd0) begin fails++; $display("FAIL idle_inc got %0d exp 0", col_add_user); end
        page_sel = 3'd5; load_start = 1;
        tick;
        load_start = 0;
        tests++; if (page_set !== 3'd5) begin fails++; $display("FAIL load_page got %0d exp 5", page_set); end
        for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
        tests++; if (FIFO_full !== 1'b0) begin fails++; $display("FAIL full_at3 got %b exp 0", FIFO_full); end
        tests++; if (FIFO_out !== 16'h1234) begin fails++; $display("FAIL head_first got %h exp 1234", FIFO_out); end
        send_byte(bytes[6], 0);
        send_byte(bytes[7], 0);
        tests++; if (FIFO_full !== 1'b1) begin fails++; $display("FAIL full_at4 got %b exp 1", FIFO_full); end
        page_sel = 3'd2; load_start = 1;
        tick;
        load_start = 0;
        tests++; if ({page_set, FIFO_full} !== {3'd5, 1'b1}) begin fails++; $display("FAIL load_start_ignored got %h exp b", {page_set, FIFO_full}); end
        pop_one;
        tests++; if (FIFO_out !== 16'h5678) begin fails++; $display("FAIL head_after_pop got %h exp 5678", FIFO_out); end
        tests++; if (FIFO_full !== 1'b0) begin fails++; $display("FAIL full_after_pop got %b exp 0", FIFO_full); end
        for (int i = 8; i < 16; i++) send_byte(bytes[i], 0);
        for (int i = 0; i < 6; i++) begin
            pop_one;
            tests++; if (FIFO_out !== heads[i]) begin fails++; $display("FAIL head_seq%0d got %h exp %h", i, FIFO_out, heads[i]); end
        end
        pop_one;
        tests++; if (FIFO_full !== 1'b0) begin fails++; $display("FAIL drained_full got %b exp 0", FIFO_full); end
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                tests++; if ({row_add_user, col_add_user} !== {9'd1, 10'd0}) begin fails++; $display("FAIL load_row_wrap got %h exp 400", {row_add_user, col_add_user}); end
            end
            tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL done_early%0d got %b exp 0", i, load_done); end
            startup_inc = 1;
            tick;
            startup_inc = 0;
        end
        tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL load_done got %b exp 1", load_done); end
        tests++; if ({page_set, row_add_user, col_add_user} !== {3'd5, 19'd0}) begin fails++; $display("FAIL load_end_addr got %h exp %h", {page_set, row_add_user, col_add_user}, {3'd5, 19'd0}); end
        tick;
        tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b exp 0", load_done); end
        for (int i = 0; i < 8; i++) send_byte(bytes[i], 0);
        tests++; if (FIFO_full !== 1'b0) begin fails++; $display("FAIL idle_rx got %b exp 0", FIFO_full); end
    endtask

    task automatic test_back_to_back;
        page_sel = 3'd3; load_start = 1;
        tick;
        load_start = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        tests++; if ({FIFO_full, overflow, FIFO_out} !== {2'b10, 16'h0001}) begin fails++; $display("FAIL level8 got %h exp 20001", {FIFO_full, overflow, FIFO_out}); end
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 1);
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL coincident_ovf got %b exp 0", overflow); end
        tests++; if (FIFO_out !== 16'h0203) begin fails++; $display("FAIL coincident_head got %h exp 0203", FIFO_out); end
    endtask

    task automatic test_overflow;
        logic [15:0] heads [7] = '{16'h0405, 16'h0607, 16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F, 16'hA1A2};
        send_byte(8'hB1, 0);
        send_byte(8'hB2, 0);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set got %b exp 1", overflow); end
        for (int i = 0; i < 7; i++) begin
            pop_one;
            tests++; if (FIFO_out !== heads[i]) begin fails++; $display("FAIL ovf_seq%0d got %h exp %h", i, FIFO_out, heads[i]); end
            if (i == 3) begin
                tests++; if (FIFO_full !== 1'b1) begin fails++; $display("FAIL level4 got %b exp 1", FIFO_full); end
            end
            if (i == 4) begin
                tests++; if (FIFO_full !== 1'b0) begin fails++; $display("FAIL level3 got %b exp 0", FIFO_full); end
            end
        end
        pop_one; pop_one; pop_one;
        for (int i = 0; i < 8; i++) send_byte(8'hC1 + 8'(i), 0);
        tests++; if ({FIFO_full, FIFO_out} !== {1'b1, 16'hC1C2}) begin fails++; $display("FAIL no_underflow got %h exp 1c1c2", {FIFO_full, FIFO_out}); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_reset_mid_load;
        send_byte(8'h77, 0);
        rst = 1;
        tick;
        rst = 0;
        tests++; if ({startup, FIFO_full, overflow} !== 3'b000) begin fails++; $display("FAIL midrst_flags got %b exp 000", {startup, FIFO_full, overflow}); end
        tests++; if (FIFO_out !== 16'h0000) begin fails++; $display("FAIL midrst_out got %h exp 0000", FIFO_out); end
        run_clear;
        tests++; if (startup !== 1'b1) begin fails++; $display("FAIL reclear got %b exp 1", startup); end
        page_sel = 3'd0; load_start = 1;
        tick;
        load_start = 0;
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        tests++; if (FIFO_out !== 16'hABCD) begin fails++; $display("FAIL pair_after_rst got %h exp abcd", FIFO_out); end
    endtask

    initial begin
        test_reset;
        test_clear;
        test_load;
        test_back_to_back;
        test_overflow;
        test_reset_mid_load;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
